commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_buffer.sv | 91 +++++++++
 tb/tb_commit_trace_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - dual-slot retire trace FIFO with drop accounting
// Optional build macro: COMMIT_TRACE_X0_SQUASH_EN (clears write flag for x0 destinations)
module commit_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [141:0] commit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_pc,
  output logic         out_wvalid,
  output logic [4:0]   out_widx,
  output logic [31:0]  out_wdata,
  output logic [15:0]  out_seq,
  output logic         overflow,
  output logic [15:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   count;
  logic [15:0]   seq_cnt;
  logic [85:0]   mem [DEPTH];

  logic        v1, v2, s1_wv, s2_wv;
  logic [69:0] e1, e2, first_e;
  logic [1:0]  n_req, n_push;
  logic [AW:0] free_slots;
  logic        drop, pop;
  logic [85:0] head;

  assign v1 = commit[141];
  assign v2 = commit[70];

`ifdef COMMIT_TRACE_X0_SQUASH_EN
  assign s1_wv = commit[108] & (commit[107:103] != 5'd0);
  assign s2_wv = commit[37] & (commit[36:32] != 5'd0);
`else
  assign s1_wv = commit[108];
  assign s2_wv = commit[37];
`endif

  assign e1      = {commit[140:109], s1_wv, commit[107:103], commit[102:71]};
  assign e2      = {commit[69:38], s2_wv, commit[36:32], commit[31:0]};
  assign first_e = v1 ? e1 : e2;

  // Free space is judged on start-of-cycle occupancy; a cycle is pushed whole or not at all.
  assign n_req      = {1'b0, v1} + {1'b0, v2};
  assign free_slots = (AW+1)'(DEPTH) - count;
  assign drop       = (AW+1)'(n_req) > free_slots;
  assign n_push     = drop ? 2'd0 : n_req;

  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign head       = mem[rptr];

  // Storage is never reset, so outputs are masked while empty.
  assign out_pc     = out_valid ? head[85:54] : 32'd0;
  assign out_wvalid = out_valid ? head[53]    : 1'b0;
  assign out_widx   = out_valid ? head[52:48] : 5'd0;
  assign out_wdata  = out_valid ? head[47:16] : 32'd0;
  assign out_seq    = out_valid ? head[15:0]  : 16'd0;

  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[wptr] <= {first_e, seq_cnt};
    if (n_push == 2'd2) mem[wptr + AW'(1)] <= {e2, seq_cnt + 16'd1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      seq_cnt    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (pop) rptr <= rptr + AW'(1);
      wptr    <= wptr + AW'(n_push);
      count   <= count + (AW+1)'(n_push) - (AW+1)'(pop);
      seq_cnt <= seq_cnt + 16'(n_push);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - scoreboard bench for commit_trace_buffer
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [141:0] commit;
  logic         out_valid, out_ready, out_wvalid, overflow;
  logic [31:0]  out_pc, out_wdata;
  logic [4:0]   out_widx;
  logic [15:0]  out_seq, drop_count;

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .commit(commit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_wvalid(out_wvalid), .out_widx(out_widx),
    .out_wdata(out_wdata), .out_seq(out_seq),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        wv;
    logic [4:0]  wi;
    logic [31:0] wd;
    logic [15:0] seq;
  } ent_t;

  ent_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          mcount = 0;
  logic [15:0] mseq = 16'd0;
  logic [15:0] mdrop = 16'd0;
  logic        movf = 1'b0;

  function automatic logic [70:0] slot(input logic v, input logic [31:0] pc, input logic wv,
                                       input logic [4:0] wi, input logic [31:0] wd);
    return {v, pc, wv, wi, wd};
  endfunction

  function automatic logic exp_wv(input logic wv, input logic [4:0] wi);
`ifdef COMMIT_TRACE_X0_SQUASH_EN
    return wv && (wi != 5'd0);
`else
    return wv;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [70:0] s);
    ent_t e;
    e.pc  = s[69:38];
    e.wv  = exp_wv(s[37], s[36:32]);
    e.wi  = s[36:32];
    e.wd  = s[31:0];
    e.seq = mseq;
    sb.push_back(e);
    mseq++;
  endtask

  // Called just after a falling edge with inputs set; checks head, models the rising edge.
  task automatic tick();
    logic [70:0] s1, s2;
    int nreq, pushes, pops;
    ent_t e;
    s1 = commit[141:71];
    s2 = commit[70:0];
    chk("out_valid", {31'd0, out_valid}, {31'd0, mcount != 0});
    pops = 0;
    if (mcount != 0 && sb.size() > 0) begin
      e = sb[0];
      chk("out_pc", out_pc, e.pc);
      chk("out_wvalid", {31'd0, out_wvalid}, {31'd0, e.wv});
      chk("out_widx", {27'd0, out_widx}, {27'd0, e.wi});
      chk("out_wdata", out_wdata, e.wd);
      chk("out_seq", {16'd0, out_seq}, {16'd0, e.seq});
      if (out_ready) begin
        void'(sb.pop_front());
        pops = 1;
      end
    end
    nreq = int'(s1[70]) + int'(s2[70]);
    pushes = 0;
    if (nreq > DEPTH - mcount) begin
      movf = 1'b1;
      if (mdrop != 16'hFFFF) mdrop++;
    end else begin
      if (s1[70]) push_exp(s1);
      if (s2[70]) push_exp(s2);
      pushes = nreq;
    end
    mcount = mcount + pushes - pops;
    @(posedge clk);
    @(negedge clk);
    commit = '0;
    chk("overflow", {31'd0, overflow}, {31'd0, movf});
    chk("drop_count", {16'd0, drop_count}, {16'd0, mdrop});
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    sb.delete();
    mcount = 0;
    mseq   = 16'd0;
    mdrop  = 16'd0;
    movf   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    commit    = '0;
    out_ready = 1'b0;
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_seq", {16'd0, out_seq}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    chk("reset_drop_count", {16'd0, drop_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Dual retire: write slot then no-write slot
    out_ready = 1'b1;
    commit = {slot(1, 32'h100, 1, 5'd5, 32'h11), slot(1, 32'h104, 0, 5'd0, 32'h0)};
    tick();
    chk("dual_head_pc", out_pc, 32'h100);
    tick();
    chk("dual_second_pc", out_pc, 32'h104);
    tick();

    // Slot 2 only
    commit = {slot(0, 32'h0, 0, 5'd0, 32'h0), slot(1, 32'h200, 1, 5'd3, 32'hDEADBEEF)};
    tick();
    chk("slot2_only_wdata", out_wdata, 32'hDEADBEEF);
    tick();

    // Write to x0
    commit = {slot(1, 32'h300, 1, 5'd0, 32'h5), 71'd0};
    tick();
    tick();

    // Fill to 15, dual dropped, single accepted
    rst_pulse();
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      commit = {slot(1, 32'h1000 + 32'(i * 4), 1, 5'(i + 1), 32'(i)), 71'd0};
      tick();
    end
    commit = {slot(1, 32'h2000, 0, 5'd0, 32'h0), slot(1, 32'h2004, 0, 5'd0, 32'h0)};
    tick();
    chk("ovf_after_dual_drop", {31'd0, overflow}, 32'd1);
    chk("drop_after_dual_drop", {16'd0, drop_count}, 32'd1);
    commit = {slot(1, 32'h3000, 1, 5'd9, 32'h99), 71'd0};
    tick();

    // Full with pop and dual push in same cycle
    out_ready = 1'b1;
    commit = {slot(1, 32'h4000, 0, 5'd0, 32'h0), slot(1, 32'h4004, 0, 5'd0, 32'h0)};
    tick();
    chk("drop_full_pop", {16'd0, drop_count}, 32'd2);
    commit = {slot(1, 32'h5000, 1, 5'd7, 32'h77), 71'd0};
    tick();
    for (int i = 0; i < 18; i++) tick();

    // Mixed traffic including pointer wrap
    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      commit = {slot(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)), $urandom),
                slot(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)), $urandom)};
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Reset mid-operation with 8 buffered entries
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      commit = {slot(1, 32'h6000 + 32'(i * 4), 0, 5'd0, 32'h0), 71'd0};
      tick();
    end
    rst_pulse();
    out_ready = 1'b1;
    commit = {slot(1, 32'h7000, 1, 5'd2, 32'h22), 71'd0};
    tick();
    chk("post_reset_seq", {16'd0, out_seq}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
